// File: rtl/fusion_pkg.sv
// Shared definitions for consumers of the fusion multiplier's partial products:
// product width, accumulator state encoding and the extend-and-shift helper.
package fusion_pkg;

    localparam int PSUM_W        = 8;
    localparam int ACC_W_DEFAULT = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    // Computed at 64 bits so every consumer can truncate to its own accumulator width.
    function automatic logic [63:0] extend_shift(
        input logic [PSUM_W-1:0] psum,
        input logic              is_signed,
        input int unsigned       shamt
    );
        logic [63:0] ext;
        ext = is_signed ? {{(64-PSUM_W){psum[PSUM_W-1]}}, psum}
                        : {{(64-PSUM_W){1'b0}}, psum};
        return ext << shamt;
    endfunction

endpackage

// File: rtl/psum_extend_shift.sv
// Combinational sign/zero extension of one fusion product followed by a
// left barrel shift that weights it for fused higher-precision modes.
module psum_extend_shift
    import fusion_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int SHIFT_W = 4
) (
    input  logic [PSUM_W-1:0]  psum_in,
    input  logic               psum_signed,
    input  logic [SHIFT_W-1:0] psum_shift,
    output logic [ACC_W-1:0]   term
);

    assign term = ACC_W'(extend_shift(psum_in, psum_signed, 32'(psum_shift)));

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates groups of shifted fusion products into one sum per group and
// hands completed sums to the consumer through a one-entry valid/ready buffer.
module psum_accumulator
    import fusion_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int LEN_W   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PSUM_W-1:0]  psum_in,
    input  logic               psum_signed,
    input  logic [SHIFT_W-1:0] psum_shift,
    input  logic               psum_valid,
    output logic               psum_ready,
    input  logic [LEN_W-1:0]   acc_len,
    output logic [ACC_W-1:0]   acc_out,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic               busy
);

    acc_state_e        state;
    acc_state_e        state_next;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  len_r;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  term;
    logic [ACC_W-1:0]  base_sum;
    logic [ACC_W-1:0]  new_sum;
    logic [LEN_W-1:0]  eff_len;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  next_count;
    logic              beat;
    logic              beat_done;
    logic              pop;

    psum_extend_shift #(
        .ACC_W   (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_extend_shift (
        .psum_in     (psum_in),
        .psum_signed (psum_signed),
        .psum_shift  (psum_shift),
        .term        (term)
    );

    // The only stall is a full output buffer that is not being drained this cycle.
    assign psum_ready = !acc_valid || acc_ready;
    assign beat       = psum_valid && psum_ready;
    assign pop        = acc_valid && acc_ready;
    assign busy       = (count != '0);
    assign eff_len    = (acc_len == '0) ? LEN_W'(1) : acc_len;
    assign new_sum    = base_sum + term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A first beat starts from zero and uses the live acc_len; later beats use the latched length.
    always_comb begin
        state_next = state;
        base_sum   = sum;
        next_count = count + LEN_W'(1);
        cur_len    = len_r;
        if (state == ST_IDLE) begin
            base_sum   = '0;
            next_count = LEN_W'(1);
            cur_len    = eff_len;
        end
        beat_done = beat && (next_count == cur_len);
        if (beat) begin
            state_next = beat_done ? ST_IDLE : ST_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            count     <= '0;
            len_r     <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
        end else begin
            if (beat) begin
                if (state == ST_IDLE) begin
                    len_r <= eff_len;
                end
                if (beat_done) begin
                    sum   <= '0;
                    count <= '0;
                end else begin
                    sum   <= new_sum;
                    count <= next_count;
                end
            end
            // A completion in the same cycle as a pop simply replaces the buffered sum.
            if (beat_done) begin
                acc_out   <= new_sum;
                acc_valid <= 1'b1;
            end else if (pop) begin
                acc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized and directed test of psum_accumulator with a queue scoreboard
// fed by a group-level arithmetic model and drained by an output monitor.
module tb_psum_accumulator;

    localparam int ACC_W   = 24;
    localparam int LEN_W   = 8;
    localparam int SHIFT_W = 4;

    logic               clk;
    logic               rst;
    logic [7:0]         psum_in;
    logic               psum_signed;
    logic [SHIFT_W-1:0] psum_shift;
    logic               psum_valid;
    logic               psum_ready;
    logic [LEN_W-1:0]   acc_len;
    logic [ACC_W-1:0]   acc_out;
    logic               acc_valid;
    logic               acc_ready;
    logic               busy;

    int total = 0;
    int bad   = 0;

    logic [ACC_W-1:0] exp_q[$];
    int    grp_cnt = 0;
    int    grp_len = 1;
    longint grp_sum = 0;
    bit    rand_ready = 0;
    bit    done;

    psum_accumulator #(
        .ACC_W   (ACC_W),
        .LEN_W   (LEN_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .psum_in     (psum_in),
        .psum_signed (psum_signed),
        .psum_shift  (psum_shift),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .acc_len     (acc_len),
        .acc_out     (acc_out),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Group-level reference: sum of weighted products, reduced modulo 2^ACC_W on completion.
    task automatic model_accept(input logic [7:0] p, input logic s, input logic [3:0] sh,
                                input logic [7:0] len, output bit complete);
        longint v;
        if (grp_cnt == 0) begin
            grp_len = (len == 0) ? 1 : int'(len);
            grp_sum = 0;
        end
        v = s ? longint'($signed(p)) : longint'(p);
        grp_sum += v * (longint'(1) << sh);
        grp_cnt++;
        complete = 0;
        if (grp_cnt == grp_len) begin
            exp_q.push_back(ACC_W'(grp_sum));
            grp_cnt  = 0;
            complete = 1;
        end
    endtask

    // Presents one beat, waits (bounded) for acceptance, then checks latency and busy.
    task automatic apply_stimulus(input logic [7:0] p, input logic s, input logic [3:0] sh,
                                  input logic [7:0] len, output bit complete);
        int waited = 0;
        bit ok = 0;
        psum_in     = p;
        psum_signed = s;
        psum_shift  = sh;
        acc_len     = len;
        psum_valid  = 1'b1;
        complete    = 0;
        while (waited < 200) begin
            @(negedge clk);
            if (psum_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_ready) acc_ready = ($urandom_range(0, 3) != 0);
            waited++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: psum_ready stayed 0 for %0d cycles", waited);
            psum_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
        model_accept(p, s, sh, len, complete);
        if (complete) check("valid_latency", 32'(acc_valid), 32'd1);
        check("busy", 32'(busy), 32'(grp_cnt != 0));
        if (rand_ready) acc_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_output(input string name, input logic [ACC_W-1:0] exp);
        check(name, 32'(acc_out), 32'(exp));
    endtask

    task automatic drain();
        int waited = 0;
        @(posedge clk);
        #1;
        acc_ready = 1'b1;
        while ((exp_q.size() != 0 || acc_valid) && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every handshake at the next edge pops one expected sum.
    always @(negedge clk) begin
        if (!rst && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_output: got 0x%0h with empty scoreboard", acc_out);
            end else begin
                check("scoreboard", 32'(acc_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst         = 1'b1;
        psum_in     = '0;
        psum_signed = 1'b0;
        psum_shift  = '0;
        psum_valid  = 1'b0;
        acc_len     = '0;
        acc_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_acc_out", 32'(acc_out), 32'd0);
        check("reset_acc_valid", 32'(acc_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_psum_ready", 32'(psum_ready), 32'd1);

        $display("[TB] unsigned group of four");
        for (int i = 0; i < 4; i++) apply_stimulus(8'h0F, 1'b0, 4'd0, 8'd4, done);
        check_output("unsigned_sum", 24'd60);

        $display("[TB] signed group of three");
        apply_stimulus(8'hF1, 1'b1, 4'd0, 8'd3, done);
        apply_stimulus(8'h02, 1'b1, 4'd0, 8'd3, done);
        apply_stimulus(8'hFF, 1'b1, 4'd0, 8'd3, done);
        check_output("signed_sum", 24'hFFFFF2);

        $display("[TB] shift and zero length");
        apply_stimulus(8'h03, 1'b0, 4'd4, 8'd2, done);
        apply_stimulus(8'h01, 1'b0, 4'd0, 8'd9, done);
        check_output("shift_sum", 24'd49);
        apply_stimulus(8'h05, 1'b0, 4'd0, 8'd0, done);
        check_output("len0_sum", 24'd5);

        $display("[TB] wrap");
        for (int i = 0; i < 4; i++) apply_stimulus(8'h80, 1'b0, 4'd15, 8'd4, done);
        check_output("wrap_sum", 24'd0);

        $display("[TB] backpressure");
        drain();
        acc_ready = 1'b0;
        apply_stimulus(8'h07, 1'b0, 4'd0, 8'd1, done);
        psum_in    = 8'h09;
        acc_len    = 8'd1;
        psum_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_psum_ready", 32'(psum_ready), 32'd0);
            check_output("bp_hold", 24'd7);
            check("bp_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
        acc_ready  = 1'b1;
        apply_stimulus(8'h09, 1'b0, 4'd0, 8'd1, done);
        check_output("bp_next", 24'd9);

        $display("[TB] back-to-back single beats");
        for (int i = 1; i <= 6; i++) apply_stimulus(8'(i * 3), 1'b0, 4'(i), 8'd1, done);

        $display("[TB] reset mid-group");
        drain();
        apply_stimulus(8'h11, 1'b0, 4'd0, 8'd4, done);
        apply_stimulus(8'h22, 1'b0, 4'd0, 8'd4, done);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        grp_cnt = 0;
        exp_q.delete();
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_valid", 32'(acc_valid), 32'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(8'h01, 1'b0, 4'd0, 8'd4, done);
        check_output("post_reset_sum", 24'd4);

        $display("[TB] randomized traffic");
        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(8'($urandom), 1'($urandom), 4'($urandom), 8'($urandom_range(0, 6)), done);
        end
        rand_ready = 0;
        drain();
        check("final_acc_valid", 32'(acc_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
